// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: receiver state encoding, frame geometry and baud divisor maths.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  localparam int unsigned BITS_PER_PACK = 10;
  localparam int unsigned DATA_BITS     = BITS_PER_PACK - 2;

  // Rounded clocks-per-bit, shared with the transmitter so both ends agree on the divisor.
  function automatic int unsigned calc_cnt_per_baud(input int unsigned clk_freq,
                                                    input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: finds the start edge, samples each bit at its centre and strobes the result
// as either rx_ok (good stop bit) or frame_err (stop bit low).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CNT_PER_BAUD = calc_cnt_per_baud(CLK_FREQ, BAUD),
  parameter int unsigned HALF_BAUD    = CNT_PER_BAUD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ok,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CNT_PER_BAUD);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntLast    = CntW'(CNT_PER_BAUD - 1);
  localparam logic [CntW-1:0] HalfLast   = CntW'(HALF_BAUD - 1);
  localparam logic [CntW-1:0] SyncSettle = CntW'(2);
  localparam logic [IdxW-1:0] LastBit    = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_ok_q, rx_ok_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_prev_q;
  logic                 rx_s;

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_ok_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d = shift_q;
            rx_ok_d   = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // The synchroniser resets high, so its output is not trusted until it has refilled.
        if (cnt_q == SyncSettle) begin
          cnt_d = cnt_q;
          if (rx_s) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StBreak;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBreak;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_ok_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_ok_q     <= rx_ok_d;
      frame_err_q <= frame_err_d;
      rx_prev_q   <= rx_s;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ok     = rx_ok_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are queued on a scoreboard as they are driven and
// matched against rx_ok / frame_err strobes, including the exact strobe cycle.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned Baud    = 100000;
  localparam int unsigned Cpb     = 10;
  // Pin change to strobe: 2 synchroniser cycles, then 9 bit times plus half a bit, plus 1.
  localparam int unsigned Latency = 2 + 9 * Cpb + Cpb / 2 + 1;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ok;
  logic       frame_err;
  logic       rx_busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  exp_t        sb[$];
  logic [7:0]  last_good = 8'h00;
  logic        prev_ok   = 1'b0;

  uart_rx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_ok    (rx_ok),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    idle(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic expect_it);
    exp_t e;
    if (expect_it) begin
      e.is_err = !stop;
      e.data   = data;
      e.cyc    = cyc + Latency;
      sb.push_back(e);
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) last_good = 8'h00;
    if (prev_ok) begin
      check_eq("ok_one_cycle", {31'd0, rx_ok}, 32'd0);
      check_eq("busy_after_ok", {31'd0, rx_busy}, 32'd0);
    end
    prev_ok = rx_ok;
    if (rx_ok || frame_err) begin
      check_eq("strobe_excl", {31'd0, rx_ok & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", {30'd0, rx_ok, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        check_eq("strobe_cycle", cyc, e.cyc);
        if (rx_ok) begin
          check_eq("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          last_good = e.data;
        end else begin
          check_eq("rx_data_held", {24'd0, rx_data}, {24'd0, last_good});
        end
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      check_eq("strobe_missing", cyc, sb[0].cyc);
      e = sb.pop_front();
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("rst_rx_ok", {31'd0, rx_ok}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy_break", {31'd0, rx_busy}, 32'd1);
    idle(6);
    check_eq("idle_after_rst", {31'd0, rx_busy}, 32'd0);

    // Single frame.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(5);
    check_eq("hold_a5", {24'd0, rx_data}, 32'h0000_00A5);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(5);
    check_eq("hold_ff", {24'd0, rx_data}, 32'h0000_00FF);

    // Short low glitch is rejected at the start-bit centre.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    check_eq("glitch_busy", {31'd0, rx_busy}, 32'd1);
    idle(20);
    check_eq("glitch_idle", {31'd0, rx_busy}, 32'd0);

    // Framing error followed by a held-low line, then recovery.
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    idle(30);
    check_eq("break_busy", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    idle(20);
    check_eq("err_hold_a5", {24'd0, rx_data}, 32'h0000_00A5);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(5);

    // Reset in the middle of data bit 4 aborts the frame silently.
    fork
      send_frame(8'h81, 1'b1, 1'b0);
      begin
        idle(Cpb + 4 * Cpb + Cpb / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("midrst_busy", {31'd0, rx_busy}, 32'd1);
      end
    join
    idle(20);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(5);

    // Line held low through reset release must not look like a start bit.
    rst = 1'b1;
    rx  = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(50);
    check_eq("lowrst_busy", {31'd0, rx_busy}, 32'd1);
    check_eq("lowrst_rx_data", {24'd0, rx_data}, 32'd0);
    rx = 1'b1;
    idle(20);
    check_eq("lowrst_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(5);

    for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
    check_eq("sb_drain", sb.size(), 32'd0);
    check_eq("final_rx_data", {24'd0, rx_data}, 32'h0000_003C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
